// File: rtl/mips_alu_pkg.sv
// rtl/mips_alu_pkg.sv - shared ALU op codes, MDU op encodings and MDU state enum
package mips_alu_pkg;

    localparam int ALUC_W  = 5;
    localparam int SHAMT_W = 5;
    localparam int MD_OP_W = 2;

    localparam logic [ALUC_W-1:0] ALUC_ADDU = 5'b00000;
    localparam logic [ALUC_W-1:0] ALUC_SUBU = 5'b00001;

    localparam logic [MD_OP_W-1:0] MD_MULTU = 2'b00;
    localparam logic [MD_OP_W-1:0] MD_DIVU  = 2'b01;
    localparam logic [MD_OP_W-1:0] MD_MTHI  = 2'b10;
    localparam logic [MD_OP_W-1:0] MD_MTLO  = 2'b11;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'b00,
        MDU_MUL  = 2'b01,
        MDU_DIV  = 2'b10
    } mdu_state_t;

endpackage

// File: rtl/alu_port_mux.sv
// rtl/alu_port_mux.sv - 2:1 select of ALU op/operand lines between EX stage and MDU sequencer
module alu_port_mux
    import mips_alu_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic               i_sel_seq,
    input  logic [ALUC_W-1:0]  i_ex_aluc,
    input  logic [DW-1:0]      i_ex_a,
    input  logic [DW-1:0]      i_ex_b,
    input  logic [SHAMT_W-1:0] i_ex_shamt,
    input  logic [ALUC_W-1:0]  i_seq_aluc,
    input  logic [DW-1:0]      i_seq_a,
    input  logic [DW-1:0]      i_seq_b,
    input  logic [SHAMT_W-1:0] i_seq_shamt,
    output logic [ALUC_W-1:0]  o_aluc,
    output logic [DW-1:0]      o_a,
    output logic [DW-1:0]      o_b,
    output logic [SHAMT_W-1:0] o_shamt
);

    assign o_aluc  = i_sel_seq ? i_seq_aluc  : i_ex_aluc;
    assign o_a     = i_sel_seq ? i_seq_a     : i_ex_a;
    assign o_b     = i_sel_seq ? i_seq_b     : i_ex_b;
    assign o_shamt = i_sel_seq ? i_seq_shamt : i_ex_shamt;

endmodule

// File: rtl/alu_mdu_sequencer.sv
// rtl/alu_mdu_sequencer.sv - iterative MULTU/DIVU sequencer borrowing the EX-stage ALU; owns HI/LO
module alu_mdu_sequencer
    import mips_alu_pkg::*;
#(
    parameter int DW   = 32,
    parameter int ITER = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ALUC_W-1:0]  ex_aluc,
    input  logic [DW-1:0]      ex_a,
    input  logic [DW-1:0]      ex_b,
    input  logic [SHAMT_W-1:0] ex_shamt,
    input  logic               md_start,
    input  logic [MD_OP_W-1:0] md_op,
    input  logic [DW-1:0]      md_rs,
    input  logic [DW-1:0]      md_rt,
    output logic [ALUC_W-1:0]  alu_aluc,
    output logic [DW-1:0]      alu_a,
    output logic [DW-1:0]      alu_b,
    output logic [SHAMT_W-1:0] alu_shamt,
    input  logic [DW-1:0]      alu_r,
    input  logic               alu_carry,
    output logic [DW-1:0]      hi,
    output logic [DW-1:0]      lo,
    output logic               busy,
    output logic               stall,
    output logic               done
);

    localparam int              CNT_W    = $clog2(ITER);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

    mdu_state_t       r_state;
    logic [DW-1:0]    r_hi;
    logic [DW-1:0]    r_lo;
    logic [DW-1:0]    r_opnd;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;

    mdu_state_t         w_state_nxt;
    logic [DW-1:0]      w_hi_nxt;
    logic [DW-1:0]      w_lo_nxt;
    logic [DW-1:0]      w_opnd_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_done_nxt;
    logic [ALUC_W-1:0]  w_seq_aluc;
    logic [DW-1:0]      w_seq_a;
    logic [DW-1:0]      w_seq_b;
    logic [DW:0]        w_div_s;
    logic               w_div_ok;
    logic               w_last;

    // Restoring divide: partial remainder shifted left by one; a set top bit always fits
    assign w_div_s  = {r_hi, r_lo[DW-1]};
    assign w_div_ok = w_div_s[DW] | ~alu_carry;
    assign w_last   = (r_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= MDU_IDLE;
            r_hi    <= '0;
            r_lo    <= '0;
            r_opnd  <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
            r_opnd  <= w_opnd_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= (w_state_nxt != MDU_IDLE);
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        w_opnd_nxt  = r_opnd;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        w_seq_aluc  = ALUC_ADDU;
        w_seq_a     = r_hi;
        w_seq_b     = '0;

        case (r_state)
            MDU_IDLE: begin
                if (md_start) begin
                    case (md_op)
                        MD_MULTU: begin
                            w_opnd_nxt  = md_rs;
                            w_lo_nxt    = md_rt;
                            w_hi_nxt    = '0;
                            w_cnt_nxt   = '0;
                            w_state_nxt = MDU_MUL;
                        end
                        MD_DIVU: begin
                            w_opnd_nxt  = md_rt;
                            w_lo_nxt    = md_rs;
                            w_hi_nxt    = '0;
                            w_cnt_nxt   = '0;
                            w_state_nxt = MDU_DIV;
                        end
                        MD_MTHI: w_hi_nxt = md_rs;
                        MD_MTLO: w_lo_nxt = md_rs;
                        default: ;
                    endcase
                end
            end
            MDU_MUL: begin
                // Shift-add: conditional add into HI, then shift {carry,HI,LO} right by one
                w_seq_aluc = ALUC_ADDU;
                w_seq_a    = r_hi;
                w_seq_b    = r_lo[0] ? r_opnd : '0;
                w_hi_nxt   = {alu_carry, alu_r[DW-1:1]};
                w_lo_nxt   = {alu_r[0], r_lo[DW-1:1]};
                w_cnt_nxt  = r_cnt + CNT_W'(1);
                if (w_last) begin
                    w_state_nxt = MDU_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            MDU_DIV: begin
                w_seq_aluc = ALUC_SUBU;
                w_seq_a    = w_div_s[DW-1:0];
                w_seq_b    = r_opnd;
                w_hi_nxt   = w_div_ok ? alu_r : w_div_s[DW-1:0];
                w_lo_nxt   = {r_lo[DW-2:0], w_div_ok};
                w_cnt_nxt  = r_cnt + CNT_W'(1);
                if (w_last) begin
                    w_state_nxt = MDU_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = MDU_IDLE;
        endcase
    end

    alu_port_mux #(.DW(DW)) u_alu_port_mux (
        .i_sel_seq   (r_state != MDU_IDLE),
        .i_ex_aluc   (ex_aluc),
        .i_ex_a      (ex_a),
        .i_ex_b      (ex_b),
        .i_ex_shamt  (ex_shamt),
        .i_seq_aluc  (w_seq_aluc),
        .i_seq_a     (w_seq_a),
        .i_seq_b     (w_seq_b),
        .i_seq_shamt ('0),
        .o_aluc      (alu_aluc),
        .o_a         (alu_a),
        .o_b         (alu_b),
        .o_shamt     (alu_shamt)
    );

    assign hi    = r_hi;
    assign lo    = r_lo;
    assign busy  = r_busy;
    assign stall = r_busy;
    assign done  = r_done;

endmodule

// File: doc/alu_mdu_sequencer.md
Name: alu_mdu_sequencer

Overview:
- Multi-cycle MULTU/DIVU controller that borrows the shared EX-stage ALU for iterative shift-add and restoring-divide steps.
- Arbitrates the ALU operand/op lines between the EX stage (idle) and itself (busy); stalls the pipeline while it owns the ALU.
- Owns the HI/LO registers; also services MTHI/MTLO.
- Sits beside the EX stage; its ALU outputs feed the ALU's a, b, aluc and shamt inputs.

Parameters:
DW, 32, datapath width (only 32 supported)
ITER, 32, iterations per multiply/divide (equals DW)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
ex_aluc  in  5  EX-stage ALU op
ex_a  in  32  EX-stage operand a
ex_b  in  32  EX-stage operand b
ex_shamt  in  5  EX-stage shift amount
md_start  in  1  issue a mul/div/move-to op this cycle
md_op  in  2  00 MULTU, 01 DIVU, 10 MTHI, 11 MTLO
md_rs  in  32  multiplicand / dividend / move source
md_rt  in  32  multiplier / divisor
alu_aluc  out  5  op to ALU
alu_a  out  32  operand a to ALU
alu_b  out  32  operand b to ALU
alu_shamt  out  5  shamt to ALU
alu_r  in  32  ALU result
alu_carry  in  1  ALU bit 32 (carry for Addu, borrow for Subu)
hi  out  32  HI register
lo  out  32  LO register
busy  out  1  iterative op in progress
stall  out  1  pipeline freeze request (equals busy)
done  out  1  one-cycle pulse: final HI/LO valid

Behaviour:
- Reset (async, any state): state IDLE; hi=0, lo=0, cnt=0, operand regs=0; busy=0, stall=0, done=0. Reset mid-operation abandons it; no done pulse.
- States: IDLE, MUL, DIV.
- IDLE:
  - ALU outputs equal ex_* combinationally.
  - md_start with MULTU: latch mcand=md_rs; lo=md_rt; hi=0; cnt=0; go to MUL.
  - md_start with DIVU: latch dvsr=md_rt; lo=md_rs; hi=0; cnt=0; go to DIV.
  - MTHI: hi=md_rs. MTLO: lo=md_rs. Both write at that edge and stay IDLE.
- MUL step, one per cycle:
  - alu_aluc=Addu (5'b00000), alu_a=hi, alu_b = lo[0] ? mcand : 0, alu_shamt=0.
  - Next {hi,lo} = {alu_carry, alu_r, lo} >> 1, keeping the low 64 bits.
- DIV step, one per cycle (restoring):
  - s = {hi, lo[31]} (33 bits).
  - alu_aluc=Subu (5'b00001), alu_a=s[31:0], alu_b=dvsr, alu_shamt=0.
  - ok = s[32] | ~alu_carry.
  - hi = ok ? alu_r : s[31:0]; lo = {lo[30:0], ok}.
- Divide by zero: no trap. Result is lo=0xFFFFFFFF, hi=dividend, which the algorithm produces naturally.
- cnt increments each step. On the step with cnt==ITER-1: go to IDLE, done=1 for the next cycle only.
- Latency: start sampled at edge T. busy=stall=1 for exactly 32 cycles (T+1..T+32). done=1 in cycle T+33, with final hi/lo stable from that cycle on.
- md_start while busy is ignored (no latch, no effect).
- hi/lo change only on the edges described above; otherwise they hold.
- busy, done and state are registers. alu_* outputs are a combinational mux selected by state.

Decomposition:
- Shared package mips_alu_pkg:
  - ALU op constants ALUC_ADDU=5'b00000, ALUC_SUBU=5'b00001, ALUC_W=5.
  - MD_OP encodings MD_MULTU, MD_DIVU, MD_MTHI, MD_MTLO.
  - State enum MDU_IDLE/MDU_MUL/MDU_DIV.
- Optional sub-module alu_port_mux: 2:1 selection of {aluc, a, b, shamt} between EX and sequencer. Everything else stays in one module.

Test Plan:
1. MULTU md_rs=0xFFFFFFFF, md_rt=0xFFFFFFFF -> busy 32 cycles, done at T+33, hi=0xFFFFFFFE, lo=0x00000001.
2. DIVU md_rs=100, md_rt=7 -> lo=14, hi=2 at done; DIVU 0xFFFFFFFF/0x80000001 -> lo=1, hi=0x7FFFFFFE.
3. DIVU md_rs=0x12345678, md_rt=0 -> lo=0xFFFFFFFF, hi=0x12345678, done at T+33.
4. IDLE passthrough: ex_aluc=5'b00110, ex_a=0xF0F0F0F0, ex_b=0x0FF00FF0 -> alu_* equal ex_* the same cycle. During MUL, alu_aluc=0 regardless of ex_*, stall=1.
5. Assert rst at cycle 10 of a MULTU -> immediately busy=0, hi=lo=0, no done. The next MULTU 3*5 gives lo=15, hi=0.
6. MTHI 0xAAAA5555 then MTLO 0x1234 on consecutive cycles -> hi/lo updated at each edge, busy stays 0. md_start(MULTU) during a busy DIVU -> ignored, DIVU result unaffected.
